// File: rtl/conv_engine.sv
// Sliding-window 2-D convolution over an R x C tile held in external X/W memories.
// Emits one biased dot product per window position over an AXI-Stream-style output.
module conv_engine #(
    parameter int INW  = 24,
    parameter int R    = 9,
    parameter int C    = 8,
    parameter int MAXK = 4,
    parameter int OUTW = 48,
    localparam int K_BITS      = $clog2(MAXK + 1),
    localparam int X_ADDR_BITS = $clog2(R * C),
    localparam int W_ADDR_BITS = $clog2(MAXK * MAXK),
    localparam int ACCW        = 2 * INW + $clog2(MAXK * MAXK)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          inputs_loaded,
    output logic                          compute_finished,
    input  logic [K_BITS-1:0]             K,
    input  logic signed [INW-1:0]         B,
    output logic [X_ADDR_BITS-1:0]        X_read_addr,
    input  logic signed [INW-1:0]         X_data,
    output logic [W_ADDR_BITS-1:0]        W_read_addr,
    input  logic signed [INW-1:0]         W_data,
    output logic signed [OUTW-1:0]        AXIS_OUT_TDATA,
    output logic                          AXIS_OUT_TVALID,
    input  logic                          AXIS_OUT_TREADY,
    output logic                          AXIS_OUT_TLAST
);
    localparam int RW = $clog2(R);
    localparam int CW = $clog2(C);
    localparam int SW = (ACCW > OUTW) ? ACCW : OUTW;
    localparam logic [X_ADDR_BITS-1:0] C_X = X_ADDR_BITS'(C);

    typedef enum logic [2:0] {IDLE, MAC, FLUSH, OUT, DONE} state_t;
    state_t state, state_nx;

    logic [K_BITS-1:0]        kq, i, j, k_end;
    logic signed [INW-1:0]    bq;
    logic [RW-1:0]            r, r_end;
    logic [CW-1:0]            c, c_end;
    logic signed [ACCW-1:0]   acc, acc_nx;
    logic signed [2*INW-1:0]  prod;
    logic                     mac_vld;
    logic                     last_pair, last_win;

    assign k_end     = kq - K_BITS'(1);
    assign r_end     = RW'(R) - RW'(kq);
    assign c_end     = CW'(C) - CW'(kq);
    assign last_pair = (i == k_end) && (j == k_end);
    assign last_win  = (r == r_end) && (c == c_end);

    // Memory data trails the address by a cycle, so a product is only
    // accumulated in the cycle after a MAC-state read.
    assign prod   = X_data * W_data;
    assign acc_nx = mac_vld ? acc + ACCW'(prod) : acc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (inputs_loaded) state_nx = MAC;
            MAC:     if (last_pair) state_nx = FLUSH;
            FLUSH:   state_nx = OUT;
            OUT:     if (AXIS_OUT_TREADY) state_nx = last_win ? DONE : MAC;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        X_read_addr      = '0;
        W_read_addr      = '0;
        AXIS_OUT_TVALID  = 1'b0;
        AXIS_OUT_TLAST   = 1'b0;
        compute_finished = 1'b0;
        case (state)
            MAC: begin
                X_read_addr = (X_ADDR_BITS'(r) + X_ADDR_BITS'(i)) * C_X
                            + X_ADDR_BITS'(c) + X_ADDR_BITS'(j);
                W_read_addr = W_ADDR_BITS'(i) * W_ADDR_BITS'(kq) + W_ADDR_BITS'(j);
            end
            OUT: begin
                AXIS_OUT_TVALID = 1'b1;
                AXIS_OUT_TLAST  = last_win;
            end
            DONE:    compute_finished = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            kq             <= '0;
            bq             <= '0;
            r              <= '0;
            c              <= '0;
            i              <= '0;
            j              <= '0;
            acc            <= '0;
            mac_vld        <= 1'b0;
            AXIS_OUT_TDATA <= '0;
        end else begin
            mac_vld <= (state == MAC);
            case (state)
                IDLE: if (inputs_loaded) begin
                    kq  <= K;
                    bq  <= B;
                    r   <= '0;
                    c   <= '0;
                    i   <= '0;
                    j   <= '0;
                    acc <= '0;
                end
                MAC: begin
                    acc <= acc_nx;
                    if (j == k_end) begin
                        j <= '0;
                        i <= i + 1'b1;
                    end else begin
                        j <= j + 1'b1;
                    end
                end
                FLUSH: begin
                    acc            <= acc_nx;
                    // Two's-complement wrap into OUTW, no saturation.
                    AXIS_OUT_TDATA <= OUTW'(SW'(acc_nx) + SW'(bq));
                end
                OUT: if (AXIS_OUT_TREADY && !last_win) begin
                    acc <= '0;
                    i   <= '0;
                    j   <= '0;
                    if (c == c_end) begin
                        c <= '0;
                        r <= r + 1'b1;
                    end else begin
                        c <= c + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_conv_engine.sv
// Randomized scoreboard bench for conv_engine: window sums from a direct
// arithmetic model are queued at set start and popped on each output handshake.
module tb_conv_engine;
    localparam int INW = 24, R = 9, C = 8, MAXK = 4, OUTW = 48;
    localparam int KB = $clog2(MAXK + 1), XA = $clog2(R * C), WA = $clog2(MAXK * MAXK);

    logic                   clk = 1'b0, reset = 1'b0, inputs_loaded = 1'b0;
    logic                   compute_finished;
    logic [KB-1:0]          K = '0;
    logic [INW-1:0]         B = '0;
    logic [XA-1:0]          X_read_addr;
    logic [WA-1:0]          W_read_addr;
    logic signed [INW-1:0]  X_data, W_data;
    logic [OUTW-1:0]        AXIS_OUT_TDATA;
    logic                   AXIS_OUT_TVALID, AXIS_OUT_TLAST;
    logic                   AXIS_OUT_TREADY = 1'b1;

    conv_engine #(.INW(INW), .R(R), .C(C), .MAXK(MAXK), .OUTW(OUTW)) dut (
        .clk(clk), .reset(reset), .inputs_loaded(inputs_loaded),
        .compute_finished(compute_finished), .K(K), .B(B),
        .X_read_addr(X_read_addr), .X_data(X_data),
        .W_read_addr(W_read_addr), .W_data(W_data),
        .AXIS_OUT_TDATA(AXIS_OUT_TDATA), .AXIS_OUT_TVALID(AXIS_OUT_TVALID),
        .AXIS_OUT_TREADY(AXIS_OUT_TREADY), .AXIS_OUT_TLAST(AXIS_OUT_TLAST)
    );

    always #5 clk = ~clk;

    typedef struct { logic [OUTW-1:0] d; logic l; } exp_t;
    exp_t sbq[$];
    int checks = 0, errors = 0, pops = 0, pulses = 0, cur_k = 2, rdy_mode = 0;
    logic signed [INW-1:0] xm [R*C];
    logic signed [INW-1:0] wm [MAXK*MAXK];

    always @(posedge clk) begin
        X_data <= xm[X_read_addr];
        W_data <= wm[W_read_addr];
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [OUTW-1:0] ref_out(int k, int r, int c, int b);
        longint s = longint'(b);
        logic [63:0] t;
        for (int i = 0; i < k; i++)
            for (int j = 0; j < k; j++)
                s += longint'(xm[(r + i) * C + c + j]) * longint'(wm[i * k + j]);
        t = s;
        return t[OUTW-1:0];
    endfunction

    task automatic push_set(input int k, input int b);
        exp_t e;
        cur_k = k;
        for (int r = 0; r <= R - k; r++)
            for (int c = 0; c <= C - k; c++) begin
                e.d = ref_out(k, r, c, b);
                e.l = (r == R - k) && (c == C - k);
                sbq.push_back(e);
            end
    endtask

    task automatic fill_rand();
        logic [31:0] t;
        for (int a = 0; a < R * C; a++) begin t = $urandom; xm[a] = t[INW-1:0]; end
        for (int a = 0; a < MAXK * MAXK; a++) begin t = $urandom; wm[a] = t[INW-1:0]; end
    endtask

    function automatic int rand_b();
        return int'($urandom_range(0, (1 << INW) - 1)) - (1 << (INW - 1));
    endfunction

    // Starts a set from IDLE and checks the first-result latency.
    task automatic start_set(input int k, input int b);
        int n = 0;
        logic [31:0] t;
        push_set(k, b);
        @(negedge clk); #1;
        K = k[KB-1:0]; B = b[INW-1:0]; inputs_loaded = 1'b1;
        while (!AXIS_OUT_TVALID && n < 100) begin
            @(negedge clk); #1;
            n++;
            if (n == 1) begin
                inputs_loaded = 1'b0;
                K = KB'($urandom_range(2, MAXK));
                t = $urandom; B = t[INW-1:0];
            end
        end
        chk("first_latency", 64'(n), 64'(k * k + 2));
    endtask

    task automatic wait_done();
        int p0 = pulses, n = 0;
        while (pulses == p0 && n < 20000) begin @(negedge clk); #1; n++; end
        chk("done_seen", 64'(pulses != p0), 64'd1);
        chk("sb_empty_at_done", 64'(sbq.size()), 64'd0);
        repeat (3) @(negedge clk);
        #1 chk("single_pulse", 64'(pulses - p0), 64'd1);
    endtask

    always begin
        int ph = 0;
        forever begin
            @(posedge clk); #1;
            ph = (ph + 1) % 4;
            case (rdy_mode)
                0:       AXIS_OUT_TREADY = 1'b1;
                1:       AXIS_OUT_TREADY = (ph == 0);
                default: AXIS_OUT_TREADY = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: scoreboard pops, stall stability, address legality.
    logic [OUTW-1:0] pd;
    logic pl, pstall = 1'b0, pcf = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            if (pstall) begin
                chk("stall_valid", 64'(AXIS_OUT_TVALID), 64'd1);
                chk("stall_tdata", 64'(AXIS_OUT_TDATA), 64'(pd));
                chk("stall_tlast", 64'(AXIS_OUT_TLAST), 64'(pl));
            end
            if (AXIS_OUT_TVALID) begin
                chk("out_addr_zero", 64'({X_read_addr, W_read_addr}), 64'd0);
            end else if (X_read_addr != 0 || W_read_addr != 0) begin
                chk("x_addr_range", 64'(int'(X_read_addr) < R * C), 64'd1);
                chk("w_addr_range", 64'(int'(W_read_addr) < cur_k * cur_k), 64'd1);
            end
            if (AXIS_OUT_TVALID && AXIS_OUT_TREADY) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_result", 64'd1, 64'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("tdata", 64'(AXIS_OUT_TDATA), 64'(e.d));
                    chk("tlast", 64'(AXIS_OUT_TLAST), 64'(e.l));
                end
                pops++;
            end
            if (compute_finished) begin
                pulses++;
                chk("cf_no_valid", 64'(AXIS_OUT_TVALID), 64'd0);
            end
            if (pcf) chk("cf_one_cycle", 64'(compute_finished), 64'd0);
            pcf    = compute_finished;
            pstall = AXIS_OUT_TVALID && !AXIS_OUT_TREADY;
            pd     = AXIS_OUT_TDATA;
            pl     = AXIS_OUT_TLAST;
        end else begin
            pstall = 1'b0;
            pcf    = 1'b0;
        end
    end

    initial begin
        int k, b, n, p0;
        for (int a = 0; a < R * C; a++) xm[a] = '0;
        for (int a = 0; a < MAXK * MAXK; a++) wm[a] = '0;
        #1;
        chk("rst_tvalid", 64'(AXIS_OUT_TVALID), 64'd0);
        chk("rst_tlast", 64'(AXIS_OUT_TLAST), 64'd0);
        chk("rst_tdata", 64'(AXIS_OUT_TDATA), 64'd0);
        chk("rst_cf", 64'(compute_finished), 64'd0);
        chk("rst_addr", 64'({X_read_addr, W_read_addr}), 64'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // All ones, K=2: every window sums to 4.
        for (int a = 0; a < R * C; a++) xm[a] = 24'sd1;
        for (int a = 0; a < MAXK * MAXK; a++) wm[a] = 24'sd1;
        rdy_mode = 0;
        p0 = pops;
        start_set(2, 0);
        wait_done();
        chk("k2_count", 64'(pops - p0), 64'd56);

        // Ramp X, unit W[0], negative bias.
        for (int a = 0; a < R * C; a++) xm[a] = INW'(a);
        for (int a = 0; a < MAXK * MAXK; a++) wm[a] = (a == 0) ? 24'sd1 : 24'sd0;
        p0 = pops;
        start_set(3, -5);
        wait_done();
        chk("k3_count", 64'(pops - p0), 64'd42);

        // Throttled consumer, K=4.
        fill_rand();
        rdy_mode = 1;
        p0 = pops;
        start_set(4, rand_b());
        wait_done();
        chk("k4_count", 64'(pops - p0), 64'd30);

        // Most-negative operands: 16 * 2^46 wraps to 0 in 48 bits.
        for (int a = 0; a < R * C; a++) xm[a] = 24'sh800000;
        for (int a = 0; a < MAXK * MAXK; a++) wm[a] = 24'sh800000;
        rdy_mode = 2;
        start_set(4, 0);
        wait_done();

        for (int s = 0; s < 3; s++) begin
            fill_rand();
            rdy_mode = int'($urandom_range(0, 2));
            start_set(int'($urandom_range(2, MAXK)), rand_b());
            wait_done();
        end

        // inputs_loaded held high across two sets; K/B changed after the first latch.
        fill_rand();
        rdy_mode = 2;
        push_set(2, 7);
        @(negedge clk); #1;
        K = 3'd2; B = 24'd7; inputs_loaded = 1'b1;
        @(negedge clk); #1;
        K = 3'd4; B = -24'sd3;
        n = 0;
        while (!compute_finished && n < 20000) begin @(negedge clk); #1; n++; end
        chk("hold_first_done", 64'(compute_finished), 64'd1);
        push_set(4, -3);
        n = 0;
        while (!AXIS_OUT_TVALID && n < 200) begin @(negedge clk); #1; n++; end
        chk("hold_restart_gap", 64'(n >= 4 * 4 + 3 && n < 200), 64'd1);
        inputs_loaded = 1'b0;
        wait_done();

        // Reset during the MAC phase of the 10th result.
        fill_rand();
        rdy_mode = 0;
        b = rand_b();
        k = 3;
        p0 = pops;
        start_set(k, b);
        n = 0;
        while (pops - p0 < 9 && n < 2000) begin @(negedge clk); #1; n++; end
        chk("reset_reach_9", 64'(pops - p0), 64'd9);
        @(negedge clk); #1;
        reset = 1'b0;
        #1;
        chk("midrst_tvalid", 64'(AXIS_OUT_TVALID), 64'd0);
        chk("midrst_tdata", 64'(AXIS_OUT_TDATA), 64'd0);
        chk("midrst_addr", 64'({X_read_addr, W_read_addr}), 64'd0);
        chk("midrst_cf", 64'(compute_finished), 64'd0);
        sbq.delete();
        repeat (3) @(negedge clk);
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        p0 = pops;
        start_set(k, b);
        wait_done();
        chk("post_reset_count", 64'(pops - p0), 64'd42);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/conv_engine.md
CONV_ENGINE -- requirements
Module: conv_engine

Interface
REQ-001 Parameter INW, default 24, bit width of X, W and B words.
REQ-002 Parameter R, default 9, number of rows in X.
REQ-003 Parameter C, default 8, number of columns in X.
REQ-004 Parameter MAXK, default 4, largest supported K.
REQ-005 Parameter OUTW, default 48, output word width.
REQ-006 Derived: K_BITS=$clog2(MAXK+1), X_ADDR_BITS=$clog2(R*C), W_ADDR_BITS=$clog2(MAXK*MAXK), ACCW=2*INW+$clog2(MAXK*MAXK).
REQ-007 Port clk, input, 1, single clock; all state changes on posedge.
REQ-008 Port reset, input, 1, asynchronous, active-low (asserted at 0).
REQ-009 Port inputs_loaded, input, 1, a complete X/W/K/B set is readable.
REQ-010 Port compute_finished, output, 1, single-cycle pulse marking the current set as consumed.
REQ-011 Port K, input, K_BITS, kernel size, valid while inputs_loaded=1; legal range 2..MAXK.
REQ-012 Port B, input, INW signed, bias value.
REQ-013 Port X_read_addr, output, X_ADDR_BITS, X memory read address.
REQ-014 Port X_data, input, INW signed, X memory data, valid one cycle after the address is presented.
REQ-015 Port W_read_addr, output, W_ADDR_BITS, W memory read address.
REQ-016 Port W_data, input, INW signed, W memory data, same one-cycle latency.
REQ-017 Port AXIS_OUT_TDATA, output, OUTW signed, convolution result.
REQ-018 Port AXIS_OUT_TVALID, output, 1, result valid.
REQ-019 Port AXIS_OUT_TREADY, input, 1, consumer ready.
REQ-020 Port AXIS_OUT_TLAST, output, 1, marks the final result of the set.

Function
REQ-021 States: IDLE, MAC, FLUSH, OUT, DONE.
REQ-022 IDLE: when inputs_loaded=1, latch K into Kq and B into Bq, set r=c=i=j=0, clear the accumulator, go to MAC.
REQ-023 MAC: issue one read pair per cycle: X_read_addr=(r+i)*C+(c+j), W_read_addr=i*Kq+j; j is inner loop, i is outer, each in 0..Kq-1.
REQ-024 Accumulation: acc += X_data*W_data one cycle after each read pair (signed INW x INW product, sign-extended to ACCW); the acc does not change on the first MAC cycle.
REQ-025 After the read pair with i=j=Kq-1: go to FLUSH; FLUSH accumulates the final product.
REQ-026 From FLUSH, go to OUT and load AXIS_OUT_TDATA = (acc + sign-extended Bq) truncated to the low OUTW bits (two's-complement wrap, no saturation).
REQ-027 Result latency: the result is valid Kq*Kq+1 cycles after the MAC entry edge.
REQ-028 OUT: TVALID=1; TDATA and TLAST are held stable until the TVALID&TREADY handshake; no reads are issued while in OUT.
REQ-029 Output order: row-major over r in 0..R-Kq and c in 0..C-Kq, giving (R-Kq+1)*(C-Kq+1) results per set.
REQ-030 TLAST=1 only with the result for r=R-Kq, c=C-Kq.
REQ-031 On handshake with a non-last result: advance c, wrapping to 0 and incrementing r at c=C-Kq; clear acc, i and j; return to MAC on the next cycle.
REQ-032 On handshake with the last result: go to DONE.
REQ-033 DONE: compute_finished=1 for exactly one cycle; TVALID=0; then go to IDLE.
REQ-034 IDLE is held at least one cycle after DONE, even if inputs_loaded=1 (this allows the bank switch), so the next set starts 2 or more cycles after the pulse.
REQ-035 inputs_loaded falling outside IDLE is ignored; K and B changes after the latch have no effect.
REQ-036 Read addresses are 0 in IDLE, OUT and DONE; addresses never exceed R*C-1 or Kq*Kq-1.
REQ-037 K<2 or K>MAXK is not checked; behaviour is undefined.

Reset
REQ-038 reset=0 asynchronously forces IDLE, acc=0, TVALID=0, TLAST=0, TDATA=0, compute_finished=0, X_read_addr=0, W_read_addr=0.
REQ-039 Reset mid-MAC or mid-OUT discards the partial set; after release, the block restarts from r=c=0 on the next inputs_loaded.

Verification
REQ-040 K=2, all X=1, all W=1, B=0, TREADY=1 -> 56 results each equal to 4; TLAST on the 56th only; one compute_finished pulse.
REQ-041 K=3, X[a]=a, W[0]=1 and others 0, B=-5 -> 42 results; result n (r=n/6, c=n%6) equals r*8+c-5.
REQ-042 K=4, TREADY toggling 1 cycle on / 3 cycles off -> TDATA and TLAST stable while stalled, no results lost or duplicated, 30 results total.
REQ-043 INW=24, X=W=-2^23, K=4, B=0, OUTW=48 -> 16*2^46 wraps to 0 in 48 bits; checks truncation.
REQ-044 inputs_loaded held at 1 across two sets -> second set starts 2 or more cycles after the compute_finished pulse, with K and B re-latched.
REQ-045 reset=0 during the 10th result's MAC -> TVALID drops immediately; after release plus inputs_loaded, the first result is r=0, c=0.
